// File: rtl/dsp_pkg.sv
// dsp_pkg: constants and types shared by the frame collector and the FFT core.
//   FFT_iter / FFT / HFFT : log2 frame length, frame length, half frame length
//   sample_t              : signed 16-bit audio sample
//   fc_state_e            : frame collector FSM states
package dsp_pkg;

    localparam int unsigned FFT_iter = 10;
    localparam int unsigned FFT      = 2 ** FFT_iter;
    localparam int unsigned HFFT     = FFT / 2;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } fc_state_e;

endpackage

// File: rtl/frame_collector_if.sv
// frame_collector_if: sample stream in, parallel frame and FFT handshake out.
//   i_valid, i_sample      : sample stream (source -> collector)
//   i_clear                : abort the partial frame
//   i_analy_finish         : FFT core is done with the held frame
//   o_frame                : parallel frame, FFT entries of sample_t
//   o_start, o_busy        : start pulse and hold indication
//   o_wr_ptr               : current write index
//   o_overrun_cnt          : dropped-sample count (only with FRAME_OVERRUN_CNT_EN)
// Modports: master = sample source / FFT side, slave = collector.
interface frame_collector_if
    import dsp_pkg::*;
#(
    parameter int unsigned FFT_iter = dsp_pkg::FFT_iter
);
    localparam int unsigned FFT = 2 ** FFT_iter;

    logic                   i_valid;
    sample_t                i_sample;
    logic                   i_clear;
    logic                   i_analy_finish;
    sample_t [FFT-1:0]      o_frame;
    logic                   o_start;
    logic                   o_busy;
    logic [FFT_iter-1:0]    o_wr_ptr;

`ifdef FRAME_OVERRUN_CNT_EN
    logic [15:0]            o_overrun_cnt;

    modport master (
        output i_valid, i_sample, i_clear, i_analy_finish,
        input  o_frame, o_start, o_busy, o_wr_ptr, o_overrun_cnt
    );

    modport slave (
        input  i_valid, i_sample, i_clear, i_analy_finish,
        output o_frame, o_start, o_busy, o_wr_ptr, o_overrun_cnt
    );
`else
    modport master (
        output i_valid, i_sample, i_clear, i_analy_finish,
        input  o_frame, o_start, o_busy, o_wr_ptr
    );

    modport slave (
        input  i_valid, i_sample, i_clear, i_analy_finish,
        output o_frame, o_start, o_busy, o_wr_ptr
    );
`endif

endinterface

// File: rtl/sample_decimator.sv
// sample_decimator: modulo-DECIM counter of enabled samples; keep is high for
// the first sample of each group of DECIM.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : a candidate sample is present
//   clr        : restart the count at 0 (the sample this cycle is not kept)
//   keep       : this sample should be stored
module sample_decimator #(
    parameter int unsigned DECIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic keep
);

    localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CW'(DECIM - 1)) cnt <= '0;
            else                       cnt <= cnt + CW'(1);
        end
    end

    assign keep = en & ~clr & (cnt == '0);

endmodule

// File: rtl/frame_collector.sv
// frame_collector: assembles a frame of FFT signed samples, pulses o_start when
// full, then holds the frame until the FFT core signals i_analy_finish.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : frame_collector_if.slave (stream, clear, handshake, frame)
// Optional feature: FRAME_OVERRUN_CNT_EN adds bus.o_overrun_cnt, a saturating
// count of samples dropped while the frame is held (cleared by i_clear).
module frame_collector
    import dsp_pkg::*;
#(
    parameter int unsigned FFT_iter = dsp_pkg::FFT_iter,
    parameter int unsigned FFT      = 2 ** FFT_iter,
    parameter int unsigned DECIM    = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    frame_collector_if.slave    bus
);

    fc_state_e              state, state_next;
    logic [FFT_iter-1:0]    wr_ptr;
    sample_t [FFT-1:0]      frame;
    logic                   in_fill;
    logic                   accept;
    logic                   last;
    logic                   dec_clr;

    assign in_fill = (state == FILL);
    assign last    = (wr_ptr == FFT_iter'(FFT - 1));

    // The decimation phase restarts on a clear in FILL and on the way back
    // into FILL after the core releases the frame.
    assign dec_clr = (in_fill & bus.i_clear) | ((state == WAIT) & bus.i_analy_finish);

    sample_decimator #(
        .DECIM(DECIM)
    ) u_decimator (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (in_fill & bus.i_valid),
        .clr   (dec_clr),
        .keep  (accept)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= FILL;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && last)        state_next = START;
            START:                              state_next = WAIT;
            WAIT:    if (bus.i_analy_finish)    state_next = FILL;
            default:                            state_next = FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
        end else if (in_fill && bus.i_clear) begin
            wr_ptr <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + FFT_iter'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame <= '0;
        end else if (accept) begin
            frame[wr_ptr] <= bus.i_sample;
        end
    end

`ifdef FRAME_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_cnt <= '0;
        end else if (bus.i_clear) begin
            overrun_cnt <= '0;
        end else if (bus.i_valid && !in_fill && overrun_cnt != '1) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end

    assign bus.o_overrun_cnt = overrun_cnt;
`endif

    assign bus.o_frame  = frame;
    assign bus.o_start  = (state == START);
    assign bus.o_busy   = ~in_fill;
    assign bus.o_wr_ptr = wr_ptr;

endmodule

// File: tb/tb_frame_collector.sv
// tb_frame_collector: two collectors (DECIM=1 and DECIM=2) checked every cycle
// against a behavioural model, plus a vector table and directed sequences.
module tb_frame_collector;
    import dsp_pkg::*;

    localparam int N = int'(FFT);
    typedef sample_t [FFT-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frame_collector_if #(.FFT_iter(FFT_iter)) bus_a ();
    frame_collector_if #(.FFT_iter(FFT_iter)) bus_b ();

    frame_collector #(.FFT_iter(FFT_iter), .FFT(FFT), .DECIM(1)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a.slave)
    );

    frame_collector #(.FFT_iter(FFT_iter), .FFT(FFT), .DECIM(2)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b.slave)
    );

    // Model: mode 0 = filling, 1 = start cycle, 2 = holding.
    frame_t m_frame [2];
    int     m_ptr   [2];
    int     m_mode  [2];
    int     m_nval  [2];
    int     m_ovr   [2];
    int     decim   [2];
    int     starts  [2];
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < N; i++) begin
                if (act[i] !== exp[i]) begin
                    $display("FAIL %s: entry %0d got %0d expected %0d", name, i,
                             int'(act[i]), int'(exp[i]));
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_frame[d] = '0;
            m_ptr[d]   = 0;
            m_mode[d]  = 0;
            m_nval[d]  = 0;
            m_ovr[d]   = 0;
        end
    endtask

    task automatic model_step(input int d, input bit v, input sample_t s, input bit c, input bit f);
        if (c) m_ovr[d] = 0;
        else if (v && m_mode[d] != 0 && m_ovr[d] < 65535) m_ovr[d]++;
        case (m_mode[d])
            0: begin
                if (c) begin
                    m_ptr[d]  = 0;
                    m_nval[d] = 0;
                end else if (v) begin
                    if (m_nval[d] % decim[d] == 0) begin
                        m_frame[d][m_ptr[d]] = s;
                        m_ptr[d] = (m_ptr[d] + 1) % N;
                        if (m_ptr[d] == 0) m_mode[d] = 1;
                    end
                    m_nval[d]++;
                end
            end
            1: m_mode[d] = 2;
            default: begin
                if (f) begin
                    m_mode[d] = 0;
                    m_nval[d] = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("A.start", int'(bus_a.o_start), int'(m_mode[0] == 1));
        check("A.busy",  int'(bus_a.o_busy),  int'(m_mode[0] != 0));
        check("A.ptr",   int'(bus_a.o_wr_ptr), m_ptr[0]);
        check_frame("A.frame", bus_a.o_frame, m_frame[0]);
        check("B.start", int'(bus_b.o_start), int'(m_mode[1] == 1));
        check("B.busy",  int'(bus_b.o_busy),  int'(m_mode[1] != 0));
        check("B.ptr",   int'(bus_b.o_wr_ptr), m_ptr[1]);
        check_frame("B.frame", bus_b.o_frame, m_frame[1]);
`ifdef FRAME_OVERRUN_CNT_EN
        check("A.ovr", int'(bus_a.o_overrun_cnt), m_ovr[0]);
        check("B.ovr", int'(bus_b.o_overrun_cnt), m_ovr[1]);
`endif
        starts[0] += int'(bus_a.o_start);
        starts[1] += int'(bus_b.o_start);
    endtask

    // Inputs are applied 1 time unit after the edge; outputs checked there too.
    task automatic cycle();
        model_step(0, bus_a.i_valid, bus_a.i_sample, bus_a.i_clear, bus_a.i_analy_finish);
        model_step(1, bus_b.i_valid, bus_b.i_sample, bus_b.i_clear, bus_b.i_analy_finish);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive_a(input bit v, input int s, input bit c, input bit f);
        bus_a.i_valid        = v;
        bus_a.i_sample       = sample_t'(s);
        bus_a.i_clear        = c;
        bus_a.i_analy_finish = f;
    endtask

    task automatic drive_b(input bit v, input int s, input bit c, input bit f);
        bus_b.i_valid        = v;
        bus_b.i_sample       = sample_t'(s);
        bus_b.i_clear        = c;
        bus_b.i_analy_finish = f;
    endtask

    typedef struct {
        bit v;
        int s;
        bit c;
        bit f;
        int e_ptr;
        int e_busy;
        int e_start;
        int idx;
        int e_val;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int s0;
        decim[0] = 1;
        decim[1] = 2;
        starts[0] = 0;
        starts[1] = 0;

        tbl[0] = '{1, 11, 0, 0, 1, 0, 0, 0, 11};   // first sample lands at 0
        tbl[1] = '{1, -3, 0, 1, 2, 0, 0, 1, -3};   // finish ignored in FILL
        tbl[2] = '{0, 55, 0, 0, 2, 0, 0, 2, 0};    // no valid, no write
        tbl[3] = '{1, 99, 1, 0, 0, 0, 0, 2, 0};    // clear drops the sample
        tbl[4] = '{1, 7, 0, 0, 1, 0, 0, 0, 7};     // restart at index 0
        tbl[5] = '{0, 0, 1, 1, 0, 0, 0, 1, -3};    // clear again, stale entry kept

        // Reset
        rst_n = 1'b0;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset ptr",   int'(bus_a.o_wr_ptr), 0);
        check("reset busy",  int'(bus_a.o_busy), 0);
        check("reset start", int'(bus_a.o_start), 0);
        check_frame("reset frame", bus_a.o_frame, '0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            drive_a(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].f);
            cycle();
            check("tbl ptr",   int'(bus_a.o_wr_ptr), tbl[i].e_ptr);
            check("tbl busy",  int'(bus_a.o_busy), tbl[i].e_busy);
            check("tbl start", int'(bus_a.o_start), tbl[i].e_start);
            check("tbl frame", int'(bus_a.o_frame[tbl[i].idx]), tbl[i].e_val);
        end

        // Full frame
        s0 = starts[0];
        for (int k = 0; k < N; k++) begin
            drive_a(1, k, 0, 0);
            cycle();
            if (k == N - 2) check("t1 no early start", int'(bus_a.o_start), 0);
        end
        check("t1 start at last", int'(bus_a.o_start), 1);
        check("t1 busy", int'(bus_a.o_busy), 1);
        for (int k = 0; k < N; k++) check("t1 frame", int'(bus_a.o_frame[k]), k);
        drive_a(0, 0, 0, 0);
        cycle();
        check("t1 start one cycle", int'(bus_a.o_start), 0);
        check("t1 busy hold", int'(bus_a.o_busy), 1);
        check("t1 start count", starts[0] - s0, 1);

        // Hold: samples dropped while WAIT
        for (int k = 0; k < 50; k++) begin
            drive_a(1, 32767, 0, 0);
            cycle();
        end
        check("t2 no second start", starts[0] - s0, 1);
        check("t2 frame kept", int'(bus_a.o_frame[N-1]), N - 1);
        check("t2 frame kept 0", int'(bus_a.o_frame[0]), 0);
`ifdef FRAME_OVERRUN_CNT_EN
        check("t2 overrun", int'(bus_a.o_overrun_cnt), 50);
`endif

        // Finish handshake with a sample in the same cycle
        drive_a(1, 1234, 0, 1);
        cycle();
        check("t3 busy low", int'(bus_a.o_busy), 0);
        check("t3 ptr", int'(bus_a.o_wr_ptr), 0);
        check("t3 dropped", int'(bus_a.o_frame[0]), 0);
        drive_a(1, -5, 0, 0);
        cycle();
        check("t3 first sample", int'(bus_a.o_frame[0]), -5);
        check("t3 ptr after", int'(bus_a.o_wr_ptr), 1);

        // Ignored finish in FILL and START
        drive_a(1, 100, 0, 1);
        cycle();
        check("t6 fill ptr", int'(bus_a.o_wr_ptr), 2);
        check("t6 fill busy", int'(bus_a.o_busy), 0);
        s0 = starts[0];
        for (int k = 2; k < N; k++) begin
            drive_a(1, k, 0, 0);
            cycle();
        end
        check("t6 in start", int'(bus_a.o_start), 1);
        drive_a(0, 0, 0, 1);
        cycle();
        check("t6 start ignores finish busy", int'(bus_a.o_busy), 1);
        check("t6 start one cycle", int'(bus_a.o_start), 0);
        drive_a(0, 0, 0, 0);
        cycle();
        check("t6 still held", int'(bus_a.o_busy), 1);
        check("t6 start count", starts[0] - s0, 1);
        drive_a(0, 0, 0, 1);
        cycle();
        check("t6 release", int'(bus_a.o_busy), 0);

        // Asynchronous reset mid-fill
        for (int k = 0; k < 300; k++) begin
            drive_a(1, 3000 + k, 0, 0);
            cycle();
        end
        check("t5 ptr 300", int'(bus_a.o_wr_ptr), 300);
        rst_n = 1'b0;
        #2;
        check("t5 async ptr", int'(bus_a.o_wr_ptr), 0);
        check("t5 async busy", int'(bus_a.o_busy), 0);
        check("t5 async start", int'(bus_a.o_start), 0);
        check_frame("t5 async frame", bus_a.o_frame, '0);
        model_reset();
        drive_a(0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_a(1, -77, 0, 0);
        cycle();
        check("t5 first after reset", int'(bus_a.o_frame[0]), -77);
        check("t5 ptr after reset", int'(bus_a.o_wr_ptr), 1);
        for (int k = 1; k < 700; k++) begin
            drive_a(1, k, 0, 0);
            cycle();
        end
        check("t5 ptr 700", int'(bus_a.o_wr_ptr), 700);
        drive_a(1, 555, 1, 0);
        cycle();
        check("t5 clear ptr", int'(bus_a.o_wr_ptr), 0);
        check("t5 clear drop", int'(bus_a.o_frame[700]), 0);
        s0 = starts[0];
        for (int k = 0; k < N - 1; k++) begin
            drive_a(1, k + 9, 0, 0);
            cycle();
        end
        check("t5 no start at 1023", starts[0] - s0, 0);
        check("t5 ptr 1023", int'(bus_a.o_wr_ptr), N - 1);
        drive_a(1, 42, 0, 0);
        cycle();
        check("t5 start at 1024", int'(bus_a.o_start), 1);
        drive_a(0, 0, 0, 0);
        cycle();
        drive_a(0, 0, 0, 1);
        cycle();
        drive_a(0, 0, 0, 0);

        // Decimation by 2
        s0 = starts[1];
        for (int k = 0; k < 2 * N; k++) begin
            drive_b(1, k, 0, 0);
            cycle();
            if (k == 2 * N - 3) check("t4 no start at 2045", int'(bus_b.o_start), 0);
            if (k == 2 * N - 2) check("t4 start after 2046", int'(bus_b.o_start), 1);
        end
        check("t4 busy", int'(bus_b.o_busy), 1);
        check("t4 start count", starts[1] - s0, 1);
        for (int j = 0; j < N; j++) check("t4 frame", int'(bus_b.o_frame[j]), 2 * j);
        drive_b(0, 0, 0, 1);
        cycle();
        drive_b(0, 0, 0, 0);

        // Randomized traffic on both collectors
        for (int n = 0; n < 8000; n++) begin
            drive_a($urandom_range(0, 9) < 7, int'($urandom), $urandom_range(0, 199) == 0,
                    $urandom_range(0, 19) == 0);
            drive_b($urandom_range(0, 9) < 8, int'($urandom), $urandom_range(0, 299) == 0,
                    $urandom_range(0, 29) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
